uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of byte requesters (2..8).
REQ-002 SHALL have parameter GAP_TICKS, default 1, giving the idle baud ticks inserted after each frame (0..15).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535, giving the clk cycles allowed between tx_start and tx_done.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester byte-available flag.
REQ-007 SHALL have port req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  N_REQ  one-hot accept strobe.
REQ-009 SHALL have port baud_tick  input  1  one-clk pulse per transmitter bit period.
REQ-010 SHALL have port tx_busy  input  1  transmitter occupied.
REQ-011 SHALL have port tx_done  input  1  one-clk pulse at the end of the stop bit.
REQ-012 SHALL have port tx_start  output  1  one-clk frame launch pulse to the transmitter.
REQ-013 SHALL have port tx_data  output  8  byte for the transmitter, held stable from launch until tx_done.
REQ-014 SHALL have port grant_id  output  clog2(N_REQ)  index of the requester owning the current frame.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port timeout_err  output  1  one-clk pulse when a frame times out.

Function
REQ-017 SHALL implement the states IDLE, START, WAIT_DONE and GAP.
REQ-018 IDLE: when any req_valid bit is set, SHALL select the first set requester in round-robin order, starting at last_grant+1 modulo N_REQ.
REQ-019 req_ready SHALL be combinational, equal to the one-hot winner, and only asserted in IDLE; the byte transfers in that cycle.
REQ-020 On transfer, the block SHALL register tx_data and grant_id, set last_grant to the winner, and go to START.
REQ-021 START: while tx_busy=1, SHALL hold with tx_start=0; with tx_busy=0, SHALL pulse tx_start for exactly one cycle, clear the timeout counter and go to WAIT_DONE.
REQ-022 WAIT_DONE: SHALL increment the timeout counter each clk cycle; on tx_done=1, SHALL go to GAP.
REQ-023 WAIT_DONE: when the counter reaches TIMEOUT_CYC-1 without tx_done, SHALL pulse timeout_err for one cycle and go to GAP.
REQ-024 If tx_done and timeout expiry occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay 0.
REQ-025 GAP: SHALL count baud_tick pulses and go to IDLE on the cycle of the GAP_TICKS-th tick; with GAP_TICKS=0, SHALL go directly from WAIT_DONE to IDLE.
REQ-026 At most one byte SHALL be accepted per frame; req_ready SHALL be 0 in START, WAIT_DONE and GAP, even if req_valid stays high.
REQ-027 A req_valid bit dropped before acceptance SHALL be ignored without error.
REQ-028 A tx_done pulse outside WAIT_DONE SHALL be ignored.
REQ-029 tx_data and grant_id SHALL remain unchanged from transfer until the next transfer.
REQ-030 Transfer-to-tx_start latency SHALL be 1 clk when tx_busy=0.

Reset
REQ-031 Asserting rst low SHALL, asynchronously and in any state, set state=IDLE, tx_start=0, tx_data=0, grant_id=0, timeout_err=0, busy=0, counters=0 and last_grant=N_REQ-1, so that requester 0 has first priority.
REQ-032 Reset during WAIT_DONE SHALL abandon the frame without a timeout_err pulse; the first cycle after release SHALL be in IDLE.

Verification
REQ-033 Single request: req_valid=0001, data 0xA5, tx_busy=0 -> req_ready=0001 in the same cycle; tx_start pulse with tx_data=0xA5 and grant_id=0 in the next cycle.
REQ-034 All requesters continuously valid with tx_done returned -> grants follow 0,1,2,3,0 with exactly one tx_start per frame.
REQ-035 After a grant to 2, req_valid=1001 -> next grant 3, then 0.
REQ-036 tx_done withheld with TIMEOUT_CYC=16 -> timeout_err pulses 16 cycles after tx_start, then GAP, then IDLE.
REQ-037 tx_busy=1 held 5 cycles after acceptance -> tx_start delayed until the first cycle with tx_busy=0; req_ready stays 0 throughout.
REQ-038 GAP_TICKS=2 -> no req_ready until the 2nd baud_tick after tx_done; reset mid-frame -> all outputs 0 and the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Byte-request and transmitter-side signals of the round-robin UART arbiter.
// master = requesters plus transmitter, slave = the arbiter itself.
interface uart_tx_arb_if #(
    parameter int N_REQ = 4
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               baud_tick;
    logic               tx_busy;
    logic               tx_done;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic [GID_W-1:0]   grant_id;
    logic               busy;
    logic               timeout_err;

    modport master (
        output req_valid, req_data, baud_tick, tx_busy, tx_done,
        input  req_ready, tx_start, tx_data, grant_id, busy, timeout_err
    );

    modport slave (
        input  req_valid, req_data, baud_tick, tx_busy, tx_done,
        output req_ready, tx_start, tx_data, grant_id, busy, timeout_err
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one byte per frame from N_REQ requesters to a UART
// transmitter, with launch hold-off, frame timeout and an inter-frame baud-tick gap.
module uart_tx_arb #(
    parameter int N_REQ       = 4,
    parameter int GAP_TICKS   = 1,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic          clk,
    input logic          rst,
    uart_tx_arb_if.slave bus
);
    localparam int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

    state_t           state;
    logic [GID_W-1:0] last_grant;
    logic [GID_W-1:0] grant_id_r;
    logic [7:0]       tx_data_r;
    logic [TO_W-1:0]  to_cnt;
    logic [3:0]       gap_cnt;

    logic             win_found;
    logic [GID_W-1:0] win_id;
    logic [N_REQ-1:0] win_onehot;
    logic [7:0]       win_byte;
    logic             to_expire;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!win_found && bus.req_valid[GID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = GID_W'(idx);
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        if (win_found) win_onehot[win_id] = 1'b1;
    end

    always_comb begin
        win_byte = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_id == GID_W'(i)) win_byte = bus.req_data[8*i +: 8];
        end
    end

    // A held reset must not look like an accepted byte to the requesters.
    assign bus.req_ready   = (state == IDLE && rst) ? win_onehot : '0;
    assign bus.tx_start    = (state == START) && !bus.tx_busy;
    assign to_expire       = (state == WAIT_DONE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1))
                             && !bus.tx_done;
    assign bus.timeout_err = to_expire;
    assign bus.busy        = (state != IDLE);
    assign bus.tx_data     = tx_data_r;
    assign bus.grant_id    = grant_id_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GID_W'(N_REQ - 1);
            grant_id_r <= '0;
            tx_data_r  <= 8'h00;
            to_cnt     <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        tx_data_r  <= win_byte;
                        grant_id_r <= win_id;
                        last_grant <= win_id;
                        state      <= START;
                    end
                end
                START: begin
                    if (!bus.tx_busy) begin
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (bus.tx_done || to_expire) begin
                        gap_cnt <= '0;
                        state   <= (GAP_TICKS == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (bus.baud_tick) begin
                        if (gap_cnt == 4'(GAP_TICKS - 1)) state <= IDLE;
                        else gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: vector table, hand-written corner sequences and a
// randomized run checked against a frame-level reference model.
module tb_uart_tx_arb;
    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TO  = 16;
    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_arb_if #(.N_REQ(N)) bus ();
    uart_tx_arb_if #(.N_REQ(N)) bus0 ();

    uart_tx_arb #(.N_REQ(N), .GAP_TICKS(GAP), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    uart_tx_arb #(.N_REQ(N), .GAP_TICKS(0), .TIMEOUT_CYC(TO)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    assign bus0.req_valid = bus.req_valid;
    assign bus0.req_data  = bus.req_data;
    assign bus0.baud_tick = bus.baud_tick;
    assign bus0.tx_busy   = bus.tx_busy;
    assign bus0.tx_done   = bus.tx_done;

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       txb, done, tick;
        logic [3:0] rdy;
        logic       st, bs;
        logic [1:0] gid;
        logic [7:0] data;
        logic       to;
    } vec_t;

    vec_t vec[25];

    function automatic vec_t mk(input logic [3:0] rv, input logic txb, input logic done,
                                input logic tick, input logic [3:0] rdy, input logic st,
                                input logic bs, input logic [1:0] gid, input logic [7:0] data,
                                input logic to);
        vec_t v;
        v.rv = rv; v.txb = txb; v.done = done; v.tick = tick; v.rdy = rdy;
        v.st = st; v.bs = bs; v.gid = gid; v.data = data; v.to = to;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] rv, input logic txb, input logic done, input logic tick);
        bus.req_valid = rv;
        bus.tx_busy   = txb;
        bus.tx_done   = done;
        bus.baud_tick = tick;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, O, O, O);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Frame-level reference: phase 0 idle, 1 accepted, 2 launched, 3 gap.
    task automatic run_random(input int ncyc);
        int phase, last, elapsed, ticks, gid, win;
        logic [7:0]  data;
        logic [31:0] rdata;
        logic [3:0]  exp_rdy;
        logic        exp_st, exp_to;
        phase = 0; last = N - 1; elapsed = 0; ticks = 0; gid = 0; data = 8'h00;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            bus.req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            rdata         = $urandom();
            bus.req_data  = rdata;
            bus.tx_busy   = ($urandom_range(0, 3) == 0);
            bus.tx_done   = ($urandom_range(0, 9) == 0);
            bus.baud_tick = ($urandom_range(0, 2) == 0);
            #1;
            win = -1;
            if (phase == 0) begin
                for (int off = 1; off <= N; off++) begin
                    if (win < 0 && bus.req_valid[(last + off) % N]) win = (last + off) % N;
                end
            end
            exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
            exp_st  = (phase == 1) && !bus.tx_busy;
            exp_to  = (phase == 2) && (elapsed == TO) && !bus.tx_done;
            chk("rnd_ready", 32'(bus.req_ready), 32'(exp_rdy));
            chk("rnd_start", 32'(bus.tx_start), 32'(exp_st));
            chk("rnd_timeout", 32'(bus.timeout_err), 32'(exp_to));
            chk("rnd_busy", 32'(bus.busy), 32'(phase != 0));
            chk("rnd_data", 32'(bus.tx_data), 32'(data));
            chk("rnd_gid", 32'(bus.grant_id), 32'(gid));
            case (phase)
                0: if (win >= 0) begin
                    data = 8'(rdata >> (8 * win));
                    gid = win; last = win; phase = 1;
                end
                1: if (exp_st) begin phase = 2; elapsed = 1; end
                2: if (bus.tx_done || exp_to) begin phase = 3; ticks = GAP; end
                   else elapsed++;
                default: if (bus.baud_tick) begin
                    ticks--;
                    if (ticks == 0) phase = 0;
                end
            endcase
        end
    endtask

    initial begin
        int n;
        logic got;
        drive(4'b0000, O, O, O);
        bus.req_data = 32'h4433_22A5;

        vec[0]  = mk(4'b0000, O, O, O, 4'b0000, O, O, 2'd0, 8'h00, O);
        vec[1]  = mk(4'b0001, O, O, O, 4'b0001, O, O, 2'd0, 8'h00, O);
        vec[2]  = mk(4'b0000, O, O, O, 4'b0000, I, I, 2'd0, 8'hA5, O);
        vec[3]  = mk(4'b1111, O, O, O, 4'b0000, O, I, 2'd0, 8'hA5, O);
        vec[4]  = mk(4'b1111, O, I, O, 4'b0000, O, I, 2'd0, 8'hA5, O);
        vec[5]  = mk(4'b1111, O, O, I, 4'b0000, O, I, 2'd0, 8'hA5, O);
        vec[6]  = mk(4'b1111, O, O, O, 4'b0000, O, I, 2'd0, 8'hA5, O);
        vec[7]  = mk(4'b1111, O, O, I, 4'b0000, O, I, 2'd0, 8'hA5, O);
        vec[8]  = mk(4'b1111, O, O, O, 4'b0010, O, O, 2'd0, 8'hA5, O);
        vec[9]  = mk(4'b1111, I, O, O, 4'b0000, O, I, 2'd1, 8'h22, O);
        vec[10] = mk(4'b1111, O, O, O, 4'b0000, I, I, 2'd1, 8'h22, O);
        vec[11] = mk(4'b1111, O, I, O, 4'b0000, O, I, 2'd1, 8'h22, O);
        vec[12] = mk(4'b1111, O, O, I, 4'b0000, O, I, 2'd1, 8'h22, O);
        vec[13] = mk(4'b1111, O, I, I, 4'b0000, O, I, 2'd1, 8'h22, O);
        vec[14] = mk(4'b0100, O, O, O, 4'b0100, O, O, 2'd1, 8'h22, O);
        vec[15] = mk(4'b0000, O, O, O, 4'b0000, I, I, 2'd2, 8'h33, O);
        vec[16] = mk(4'b0000, O, I, O, 4'b0000, O, I, 2'd2, 8'h33, O);
        vec[17] = mk(4'b0000, O, O, I, 4'b0000, O, I, 2'd2, 8'h33, O);
        vec[18] = mk(4'b0000, O, O, I, 4'b0000, O, I, 2'd2, 8'h33, O);
        vec[19] = mk(4'b1001, O, O, O, 4'b1000, O, O, 2'd2, 8'h33, O);
        vec[20] = mk(4'b1001, O, O, O, 4'b0000, I, I, 2'd3, 8'h44, O);
        vec[21] = mk(4'b1001, O, I, O, 4'b0000, O, I, 2'd3, 8'h44, O);
        vec[22] = mk(4'b1001, O, O, I, 4'b0000, O, I, 2'd3, 8'h44, O);
        vec[23] = mk(4'b1001, O, O, I, 4'b0000, O, I, 2'd3, 8'h44, O);
        vec[24] = mk(4'b1001, O, O, O, 4'b0001, O, O, 2'd3, 8'h44, O);

        // Reset state while held.
        #2;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_data", 32'(bus.tx_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            drive(vec[i].rv, vec[i].txb, vec[i].done, vec[i].tick);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vec[i].rdy));
            chk($sformatf("v%0d_start", i), 32'(bus.tx_start), 32'(vec[i].st));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(vec[i].bs));
            chk($sformatf("v%0d_gid", i), 32'(bus.grant_id), 32'(vec[i].gid));
            chk($sformatf("v%0d_data", i), 32'(bus.tx_data), 32'(vec[i].data));
            chk($sformatf("v%0d_to", i), 32'(bus.timeout_err), 32'(vec[i].to));
        end

        // Timeout: pulse 16 cycles after launch, then gap, then idle.
        do_reset();
        @(negedge clk); drive(4'b0001, O, O, O); #1;
        chk("to_accept", 32'(bus.req_ready), 32'h1);
        @(negedge clk); drive(4'b0000, O, O, O); #1;
        chk("to_launch", 32'(bus.tx_start), 32'h1);
        n = 0; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk); #1;
            if (bus.timeout_err) begin got = 1'b1; n = c; end
        end
        chk("to_latency", 32'(n), 32'd16);
        @(negedge clk); drive(4'b0001, O, O, I); #1;
        chk("to_pulse_len", 32'(bus.timeout_err), 32'd0);
        chk("to_gap_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk); drive(4'b0001, O, O, I); #1;
        chk("to_gap_busy", 32'(bus.busy), 32'd1);
        @(negedge clk); drive(4'b0001, O, O, O); #1;
        chk("to_idle_ready", 32'(bus.req_ready), 32'h1);

        // tx_done on the expiry cycle wins over the timeout.
        do_reset();
        @(negedge clk); drive(4'b0001, O, O, O);
        @(negedge clk); drive(4'b0000, O, O, O);
        for (int c = 1; c < 16; c++) @(negedge clk);
        @(negedge clk); drive(4'b0000, O, I, O); #1;
        chk("tie_timeout", 32'(bus.timeout_err), 32'd0);
        @(negedge clk); drive(4'b0000, O, O, O); #1;
        chk("tie_gap_busy", 32'(bus.busy), 32'd1);
        chk("tie_no_late_to", 32'(bus.timeout_err), 32'd0);

        // Transmitter busy for 5 cycles after acceptance delays the launch.
        do_reset();
        @(negedge clk); drive(4'b0001, I, O, O); #1;
        chk("hold_accept", 32'(bus.req_ready), 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); drive(4'b1111, I, O, O); #1;
            chk("hold_start", 32'(bus.tx_start), 32'd0);
            chk("hold_ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clk); drive(4'b1111, O, O, O); #1;
        chk("hold_launch", 32'(bus.tx_start), 32'd1);
        chk("hold_data", 32'(bus.tx_data), 32'hA5);

        // GAP_TICKS=0 instance returns to idle straight after tx_done.
        do_reset();
        @(negedge clk); drive(4'b0001, O, O, O);
        @(negedge clk); drive(4'b0000, O, O, O);
        @(negedge clk); drive(4'b0000, O, I, O);
        @(negedge clk); drive(4'b0000, O, O, O); #1;
        chk("gap0_idle", 32'(bus0.busy), 32'd0);
        chk("gap2_still_busy", 32'(bus.busy), 32'd1);

        // Asynchronous reset in the middle of a frame.
        do_reset();
        @(negedge clk); drive(4'b0100, O, O, O);
        @(negedge clk); drive(4'b0000, O, O, O);
        @(negedge clk); @(negedge clk); #1;
        chk("mid_pre_gid", 32'(bus.grant_id), 32'd2);
        rst = 1'b0; drive(4'b1111, O, O, O); #1;
        chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_gid", 32'(bus.grant_id), 32'd0);
        chk("mid_rst_data", 32'(bus.tx_data), 32'd0);
        chk("mid_rst_start", 32'(bus.tx_start), 32'd0);
        chk("mid_rst_to", 32'(bus.timeout_err), 32'd0);
        @(negedge clk); rst = 1'b1; #1;
        chk("mid_post_ready", 32'(bus.req_ready), 32'h1);

        do_reset();
        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
